alarm_bank: RTL and testbench

Parametrised multi-slot alarm controller, successor to the single-alarm block. Holds N_ALARMS editable alarm times with per-slot enable, edits them from the five push-buttons with internal edge detection and modular field arithmetic, and raises a ring request with snooze, dismiss and auto-timeout. Sits between the time-of-day counter (current hour/minute/second plus a 1 Hz strobe) and the display mux / melody player.

---
 rtl/alarm_pkg.sv | 28 ++
 rtl/btn_edge.sv | 35 +++
 rtl/alarm_bank.sv | 225 ++++++++++++++++++++++
 tb/tb_alarm_bank.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alarm_pkg
// Purpose  : Shared types and constants for the multi-slot alarm controller:
//            controller states, edit-field encoding and time-field limits.
// Revision : 1.0 - initial release
// ============================================================================
package alarm_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EDIT_SEC  = 3'd1,
    EDIT_MIN  = 3'd2,
    EDIT_HOUR = 3'd3,
    RING      = 3'd4
  } state_t;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_SEC  = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;
  localparam logic [1:0] FLD_HOUR = 2'd3;

  localparam int MAX_SEC  = 59;
  localparam int MAX_MIN  = 59;
  localparam int MAX_HOUR = 23;

endpackage
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_edge
// Purpose  : Rising-edge detector for a vector of debounced button levels.
//            The first clock after reset only captures history, so a button
//            held through reset release never produces a press.
// Revision : 1.0 - initial release
// ============================================================================
module btn_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] r_prev;
  logic         r_armed;

  // Capture the previous level and arm the detector one cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= level;
      r_armed <= 1'b1;
    end
  end

  assign rise = level & ~r_prev & {W{r_armed}};

endmodule
`default_nettype wire

// File: rtl/alarm_bank.sv
`default_nettype none
// ============================================================================
// Module   : alarm_bank
// Purpose  : N-slot alarm controller. Button-driven slot selection, enable
//            toggling and field editing; match against the time-of-day
//            counter on each second strobe; ring with snooze, dismiss and
//            auto-timeout.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int N_ALARMS   = 4,
  parameter int TW         = 11,
  parameter int RING_SECS  = 30,
  parameter int SNOOZE_MIN = 5,
  localparam int SW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                newclk,
  input  logic                rst_n,
  input  logic                sec_tick,
  input  logic [TW-1:0]       hour,
  input  logic [TW-1:0]       minute,
  input  logic [TW-1:0]       second,
  input  logic                up,
  input  logic                down,
  input  logic                left,
  input  logic                right,
  input  logic                middle,
  output logic [SW-1:0]       sel,
  output logic [1:0]          edit_field,
  output logic [TW-1:0]       disp_hour,
  output logic [TW-1:0]       disp_minute,
  output logic [TW-1:0]       disp_second,
  output logic [N_ALARMS-1:0] enabled,
  output logic                ring,
  output logic [SW-1:0]       ring_id
);

  localparam int CW = $clog2(RING_SECS + 1);

  localparam logic [TW-1:0] c_max_sec  = TW'(MAX_SEC);
  localparam logic [TW-1:0] c_max_min  = TW'(MAX_MIN);
  localparam logic [TW-1:0] c_max_hour = TW'(MAX_HOUR);
  localparam logic [TW-1:0] c_snooze   = TW'(SNOOZE_MIN);
  localparam logic [TW-1:0] c_min_mod  = TW'(MAX_MIN + 1);
  localparam logic [SW-1:0] c_last     = SW'(N_ALARMS - 1);
  localparam logic [CW-1:0] c_ring_ld  = CW'(RING_SECS);
  localparam logic [CW-1:0] c_cnt_one  = CW'(1);

  // Modular +1 / -1 on a single time field; no carry out.
  function automatic logic [TW-1:0] wrap_inc(input logic [TW-1:0] v, input logic [TW-1:0] max);
    return (v >= max) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [TW-1:0] wrap_dec(input logic [TW-1:0] v, input logic [TW-1:0] max);
    return (v == '0) ? max : v - 1'b1;
  endfunction

  // Button vector order: {middle, right, left, down, up}
  logic [4:0] w_press;
  logic       w_up, w_down, w_left, w_right, w_mid, w_any_btn;

  btn_edge #(.W(5)) u_btn_edge (
    .clk   (newclk),
    .rst_n (rst_n),
    .level ({middle, right, left, down, up}),
    .rise  (w_press)
  );

  assign w_up      = w_press[0];
  assign w_down    = w_press[1];
  assign w_left    = w_press[2];
  assign w_right   = w_press[3];
  assign w_mid     = w_press[4];
  assign w_any_btn = |w_press;

  state_t                r_state;
  logic [SW-1:0]         r_sel;
  logic [1:0]            r_field;
  logic [N_ALARMS-1:0]   r_en;
  logic                  r_ring;
  logic [SW-1:0]         r_ring_id;
  logic [CW-1:0]         r_cnt;
  logic [TW-1:0]         r_hour [N_ALARMS];
  logic [TW-1:0]         r_min  [N_ALARMS];
  logic [TW-1:0]         r_sec  [N_ALARMS];

  // Per-slot match against the current time on the second strobe.
  logic [N_ALARMS-1:0] w_hit;
  for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_match
    assign w_hit[gi] = sec_tick & r_en[gi] &
                       (r_hour[gi] == hour) & (r_min[gi] == minute) & (r_sec[gi] == second);
  end

  // Lowest-index matching slot wins.
  logic          w_any_hit;
  logic [SW-1:0] w_hit_id;
  always_comb begin
    w_any_hit = 1'b0;
    w_hit_id  = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any_hit = 1'b1;
        w_hit_id  = SW'(i);
      end
    end
  end

  // Snoozed time of the ringing slot: minutes carry into hours, hours wrap.
  logic [TW-1:0] w_snz_sum, w_snz_min, w_snz_hour;
  always_comb begin
    w_snz_sum  = r_min[r_ring_id] + c_snooze;
    w_snz_min  = w_snz_sum;
    w_snz_hour = r_hour[r_ring_id];
    if (w_snz_sum > c_max_min) begin
      w_snz_min  = w_snz_sum - c_min_mod;
      w_snz_hour = wrap_inc(r_hour[r_ring_id], c_max_hour);
    end
  end

  // Controller state machine, slot storage and all registered outputs.
  always_ff @(posedge newclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_field   <= FLD_NONE;
      r_en      <= '0;
      r_ring    <= 1'b0;
      r_ring_id <= '0;
      r_cnt     <= '0;
      for (int i = 0; i < N_ALARMS; i++) begin
        r_hour[i] <= '0;
        r_min[i]  <= '0;
        r_sec[i]  <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mid) begin
            r_hour[r_sel] <= hour;
            r_min[r_sel]  <= minute;
            r_sec[r_sel]  <= second;
            r_state       <= EDIT_SEC;
            r_field       <= FLD_SEC;
          end else if (w_up || w_down) begin
            if (w_up) r_en[r_sel] <= ~r_en[r_sel];
          end else if (w_left) begin
            r_sel <= (r_sel == '0) ? c_last : r_sel - 1'b1;
          end else if (w_right) begin
            r_sel <= (r_sel == c_last) ? '0 : r_sel + 1'b1;
          end else if (w_any_hit && !w_any_btn) begin
            r_ring    <= 1'b1;
            r_ring_id <= w_hit_id;
            r_cnt     <= c_ring_ld;
            r_state   <= RING;
          end
        end

        EDIT_SEC, EDIT_MIN, EDIT_HOUR: begin
          if (w_mid) begin
            r_en[r_sel] <= 1'b1;
            r_state     <= IDLE;
            r_field     <= FLD_NONE;
          end else if (w_up || w_down) begin
            if (r_state == EDIT_SEC)
              r_sec[r_sel] <= w_up ? wrap_inc(r_sec[r_sel], c_max_sec)
                                   : wrap_dec(r_sec[r_sel], c_max_sec);
            else if (r_state == EDIT_MIN)
              r_min[r_sel] <= w_up ? wrap_inc(r_min[r_sel], c_max_min)
                                   : wrap_dec(r_min[r_sel], c_max_min);
            else
              r_hour[r_sel] <= w_up ? wrap_inc(r_hour[r_sel], c_max_hour)
                                    : wrap_dec(r_hour[r_sel], c_max_hour);
          end else if (w_right) begin
            if (r_state == EDIT_SEC)      begin r_state <= EDIT_MIN;  r_field <= FLD_MIN;  end
            else if (r_state == EDIT_MIN) begin r_state <= EDIT_HOUR; r_field <= FLD_HOUR; end
            else                          begin r_state <= EDIT_SEC;  r_field <= FLD_SEC;  end
          end else if (w_left) begin
            if (r_state == EDIT_SEC)      begin r_state <= EDIT_HOUR; r_field <= FLD_HOUR; end
            else if (r_state == EDIT_HOUR) begin r_state <= EDIT_MIN; r_field <= FLD_MIN;  end
            else                          begin r_state <= EDIT_SEC;  r_field <= FLD_SEC;  end
          end
        end

        RING: begin
          if (w_mid) begin
            r_ring  <= 1'b0;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (w_up || w_down) begin
            r_min[r_ring_id]  <= w_snz_min;
            r_hour[r_ring_id] <= w_snz_hour;
            r_ring            <= 1'b0;
            r_cnt             <= '0;
            r_state           <= IDLE;
          end else if (sec_tick) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt <= c_cnt_one) begin
              r_ring  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end

        default: begin
          r_state <= IDLE;
          r_field <= FLD_NONE;
          r_ring  <= 1'b0;
        end
      endcase
    end
  end

  assign sel         = r_sel;
  assign edit_field  = r_field;
  assign enabled     = r_en;
  assign ring        = r_ring;
  assign ring_id     = r_ring_id;
  assign disp_hour   = r_hour[r_sel];
  assign disp_minute = r_min[r_sel];
  assign disp_second = r_sec[r_sel];

endmodule
`default_nettype wire

// File: tb/tb_alarm_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_bank
// Purpose  : Self-checking bench for alarm_bank. Expected values are queued
//            when stimulus is applied and popped when the outputs settle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_bank;

  localparam int N  = 4;
  localparam int SW = 2;
  localparam int TW = 11;

  logic          newclk = 1'b0;
  logic          rst_n;
  logic          sec_tick;
  logic [TW-1:0] hour, minute, second;
  logic [4:0]    btn;  // {middle, right, left, down, up}
  logic [SW-1:0] sel;
  logic [1:0]    edit_field;
  logic [TW-1:0] disp_hour, disp_minute, disp_second;
  logic [N-1:0]  enabled;
  logic          ring;
  logic [SW-1:0] ring_id;

  int n_checks = 0;
  int n_errors = 0;

  string       nq[$];
  logic [31:0] vq[$];
  string       en_name;
  logic [31:0] ev;

  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_MID = 4;

  alarm_bank #(.N_ALARMS(N), .TW(TW), .RING_SECS(30), .SNOOZE_MIN(5)) dut (
    .newclk(newclk), .rst_n(rst_n), .sec_tick(sec_tick),
    .hour(hour), .minute(minute), .second(second),
    .up(btn[0]), .down(btn[1]), .left(btn[2]), .right(btn[3]), .middle(btn[4]),
    .sel(sel), .edit_field(edit_field),
    .disp_hour(disp_hour), .disp_minute(disp_minute), .disp_second(disp_second),
    .enabled(enabled), .ring(ring), .ring_id(ring_id)
  );

  always #5 newclk = ~newclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] disp_val();
    return 32'(disp_hour) * 10000 + 32'(disp_minute) * 100 + 32'(disp_second);
  endfunction

  task automatic expect_val(input string name, input logic [31:0] v);
    nq.push_back(name);
    vq.push_back(v);
  endtask

  task automatic cyc();
    @(posedge newclk);
    #1;
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    cyc();
    btn[b] = 1'b0;
    cyc();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour   = TW'(h);
    minute = TW'(m);
    second = TW'(s);
  endtask

  task automatic sec_pulse(input int h, input int m, input int s);
    set_time(h, m, s);
    sec_tick = 1'b1;
    cyc();
    sec_tick = 1'b0;
  endtask

  task automatic test_reset();
    expect_val("rst_sel", 0); expect_val("rst_field", 0); expect_val("rst_en", 0);
    expect_val("rst_ring", 0); expect_val("rst_disp", 0);
    cyc();
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(sel) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, sel, ev); end
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(edit_field) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, edit_field, ev); end
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(enabled) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, enabled, ev); end
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if ({31'd0, ring} !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, ring, ev); end
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (disp_val() !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, disp_val(), ev); end
  endtask

  task automatic test_sel_wrap();
    int exp_sel[4] = '{3, 0, 3, 0};
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin press(B_RIGHT); press(B_RIGHT); press(B_RIGHT); end
      else if (k == 2) press(B_LEFT);
      else press(B_RIGHT);
      expect_val($sformatf("sel_wrap_%0d", k), 32'(exp_sel[k]));
      en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
      if (32'(sel) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, sel, ev); end
    end
  endtask

  task automatic test_set_alarm_and_ring();
    set_time(0, 0, 0);
    press(B_MID);
    expect_val("edit_enter_field", 1);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(edit_field) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, edit_field, ev); end
    press(B_RIGHT);
    repeat (30) press(B_UP);
    press(B_RIGHT);
    repeat (7) press(B_UP);
    expect_val("edit_hour_field", 3); expect_val("slot0_073000", 73000);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(edit_field) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, edit_field, ev); end
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (disp_val() !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, disp_val(), ev); end
    press(B_MID);
    expect_val("edit_exit_en", 32'b0001);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(enabled) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, enabled, ev); end
    sec_pulse(7, 29, 59);
    expect_val("no_ring_072959", 0);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if ({31'd0, ring} !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, ring, ev); end
    sec_pulse(7, 30, 0);
    expect_val("ring_073000", 1); expect_val("ring_id_0", 0);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if ({31'd0, ring} !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, ring, ev); end
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(ring_id) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, ring_id, ev); end
    cyc();
    press(B_MID);
    expect_val("dismiss_ring", 0); expect_val("dismiss_keeps_en", 32'b0001);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if ({31'd0, ring} !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, ring, ev); end
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(enabled) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, enabled, ev); end
  endtask

  task automatic test_button_beats_match();
    set_time(7, 30, 0);
    sec_tick = 1'b1;
    btn[B_RIGHT] = 1'b1;
    cyc();
    sec_tick = 1'b0;
    btn[B_RIGHT] = 1'b0;
    expect_val("coinc_sel", 1); expect_val("coinc_no_ring", 0);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(sel) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, sel, ev); end
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if ({31'd0, ring} !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, ring, ev); end
    cyc();
  endtask

  task automatic test_edit_wrap();
    set_time(0, 17, 59);
    press(B_MID);
    press(B_UP);
    expect_val("sec_59_up", 1700);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (disp_val() !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, disp_val(), ev); end
    press(B_DOWN);
    press(B_LEFT);
    expect_val("left_sec_to_hour", 3);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(edit_field) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, edit_field, ev); end
    press(B_DOWN);
    expect_val("hour_0_down", 231759);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (disp_val() !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, disp_val(), ev); end
    press(B_UP);
    press(B_LEFT);
    repeat (18) press(B_DOWN);
    expect_val("min_wrap_down", 5959);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (disp_val() !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, disp_val(), ev); end
    press(B_MID);
    press(B_UP);
    expect_val("toggle_off_slot1", 32'b0001);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(enabled) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, enabled, ev); end
  endtask

  task automatic test_snooze();
    set_time(23, 58, 0);
    press(B_RIGHT);
    press(B_MID);
    press(B_MID);
    sec_pulse(23, 58, 0);
    expect_val("snz_ring", 1); expect_val("snz_ring_id", 2);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if ({31'd0, ring} !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, ring, ev); end
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(ring_id) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, ring_id, ev); end
    cyc();
    press(B_UP);
    expect_val("snz_ring_off", 0); expect_val("snz_time", 300);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if ({31'd0, ring} !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, ring, ev); end
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (disp_val() !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, disp_val(), ev); end
    press(B_UP);
  endtask

  task automatic test_timeout_priority();
    set_time(12, 0, 0);
    press(B_LEFT);
    press(B_MID); press(B_MID);
    press(B_RIGHT); press(B_RIGHT);
    press(B_MID); press(B_MID);
    expect_val("to_en", 32'b1011);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(enabled) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, enabled, ev); end
    sec_pulse(12, 0, 0);
    expect_val("lowest_id", 1);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(ring_id) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, ring_id, ev); end
    for (int k = 1; k <= 29; k++) begin
      cyc();
      sec_pulse(12, 0, k);
    end
    expect_val("ring_after_29", 1);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if ({31'd0, ring} !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, ring, ev); end
    cyc();
    sec_pulse(12, 0, 30);
    expect_val("ring_off_30th", 0);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if ({31'd0, ring} !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, ring, ev); end
    cyc();
  endtask

  task automatic test_reset_mid_edit();
    set_time(1, 2, 3);
    btn[B_MID] = 1'b1;
    cyc();
    press(B_RIGHT);
    expect_val("pre_rst_field", 2);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(edit_field) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, edit_field, ev); end
    #2 rst_n = 1'b0;
    #1;
    expect_val("async_rst_field", 0); expect_val("async_rst_sel", 0);
    expect_val("async_rst_en", 0); expect_val("async_rst_disp", 0);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(edit_field) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, edit_field, ev); end
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(sel) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, sel, ev); end
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(enabled) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, enabled, ev); end
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (disp_val() !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, disp_val(), ev); end
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    expect_val("held_mid_no_edit", 0); expect_val("held_mid_disp", 0);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(edit_field) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, edit_field, ev); end
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (disp_val() !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, disp_val(), ev); end
    btn[B_MID] = 1'b0;
    cyc();
    press(B_MID);
    expect_val("fresh_mid_edit", 1); expect_val("fresh_mid_copy", 10203);
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (32'(edit_field) !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, edit_field, ev); end
    en_name = nq.pop_front(); ev = vq.pop_front(); n_checks++;
    if (disp_val() !== ev) begin n_errors++; $display("FAIL %s got %0d want %0d", en_name, disp_val(), ev); end
  endtask

  initial begin
    rst_n    = 1'b0;
    sec_tick = 1'b0;
    btn      = '0;
    set_time(0, 0, 0);
    cyc();
    test_reset();
    rst_n = 1'b1;
    cyc();
    test_sel_wrap();
    test_set_alarm_and_ring();
    test_button_beats_match();
    test_edit_wrap();
    test_snooze();
    test_timeout_priority();
    test_reset_mid_edit();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
